lab4_hilo_mult: RTL

LAB4_HILO_MULT -- requirements
Module: lab4_hilo_mult

---
 rtl/lab4_hilo_mult.sv | 119 +++++++++++
 1 files changed

// File: rtl/lab4_hilo_mult.sv
// HI/LO multiply unit: 32x32 signed/unsigned sequential multiplier, one shift-add step per cycle,
// with combinational mfhi/mflo read port and pipeline stall while a product is in flight.
module lab4_hilo_mult (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  op,
    input  logic        enhilo,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] hilo_out,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    // state | meaning
    // IDLE  | waiting for mult/multu; HI/LO readable
    // RUN   | 32 shift-add steps on latched magnitudes
    // FIX   | apply result sign, write HI/LO
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [3:0] OP_MULT    = 4'b0110;
    localparam logic [3:0] OP_MULTU   = 4'b0111;
    localparam logic [5:0] FUNCT_MFHI = 6'b010000;

    state_t      state;
    state_t      state_next;
    logic        start;
    logic        start_signed;
    logic [31:0] mag_rs;
    logic [31:0] mag_rt;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        is_signed;
    logic        neg;
    logic [63:0] acc;
    logic [63:0] partial;
    logic [63:0] product;
    logic [4:0]  cnt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done_q;

    assign start        = enhilo && (op == OP_MULT || op == OP_MULTU) && (state == IDLE);
    assign start_signed = (op == OP_MULT);

    // 0x80000000 negates to itself, which read unsigned is exactly 2^31
    assign mag_rs = (start_signed && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
    assign mag_rt = (start_signed && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;

    assign partial = mag_b[cnt] ? ({32'd0, mag_a} << cnt) : 64'd0;
    assign product = (is_signed && neg) ? (~acc + 64'd1) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_a     <= 32'd0;
            mag_b     <= 32'd0;
            is_signed <= 1'b0;
            neg       <= 1'b0;
            acc       <= 64'd0;
            cnt       <= 5'd0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_a     <= mag_rs;
                        mag_b     <= mag_rt;
                        is_signed <= start_signed;
                        neg       <= start_signed && (rs_data[31] ^ rt_data[31]);
                        acc       <= 64'd0;
                        cnt       <= 5'd0;
                    end
                end
                RUN: begin
                    acc <= acc + partial;
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    hi <= product[63:32];
                    lo <= product[31:0];
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign stall    = busy && enhilo;
    assign done     = done_q;
    assign hilo_out = (funct == FUNCT_MFHI) ? hi : lo;

endmodule
